// File: rtl/usr_pkg.sv
// -----------------------------------------------------------------------------
// usr_pkg -- shared definitions for the universal shift register (usr_seq).
//
// Contents:
//   OP_*         4-bit opcodes accepted on the command interface
//                (8..15 are unassigned and behave as NOP)
//   usr_state_t  control FSM state (S_IDLE, S_BUSY)
//   eff_rot()    effective rotate distance, i.e. amount modulo register width
// -----------------------------------------------------------------------------
package usr_pkg;

   localparam logic [3:0] OP_NOP  = 4'd0;
   localparam logic [3:0] OP_LOAD = 4'd1;
   localparam logic [3:0] OP_SER  = 4'd2;
   localparam logic [3:0] OP_ROR  = 4'd3;
   localparam logic [3:0] OP_ROL  = 4'd4;
   localparam logic [3:0] OP_SHL  = 4'd5;
   localparam logic [3:0] OP_SHR  = 4'd6;
   localparam logic [3:0] OP_SAR  = 4'd7;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_BUSY = 1'b1
   } usr_state_t;

   // Rotating by a multiple of the width is the identity, so only the
   // remainder matters.
   function automatic int eff_rot(input int amt, input int width);
      return amt % width;
   endfunction

endpackage

// File: rtl/usr_shift_unit.sv
// -----------------------------------------------------------------------------
// usr_shift_unit -- combinational next-value generator for usr_seq.
//
// Configuration macro: USR_BARREL_EN
//   undefined : every op advances the register by exactly one bit position;
//               the caller iterates to reach the full amount
//   defined   : ROR/ROL/SHL/SHR/SAR apply the full `amt` in one step
//               (barrel shifter); SER still advances one bit
//
// Ports:
//   q      in   WIDTH   current register contents
//   op     in   4       opcode (usr_pkg::OP_*)
//   amt    in   AMT_W   shift amount (used only in the barrel build)
//   sin    in   1       serial input bit for SER
//   q_next out  WIDTH   value the register takes if this step is applied
// -----------------------------------------------------------------------------
module usr_shift_unit
   import usr_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int AMT_W = $clog2(WIDTH) + 1
) (
   input  logic [WIDTH-1:0] q,
   input  logic [3:0]       op,
   input  logic [AMT_W-1:0] amt,
   input  logic             sin,
   output logic [WIDTH-1:0] q_next
);

`ifdef USR_BARREL_EN

   logic [2*WIDTH-1:0] dbl;
   int                 n;
   int                 r;
   int                 s;

   always_comb begin
      // NOTE: every variable driven here gets a default first, so no path
      // leaves one unassigned and no latch is inferred.
      q_next = q;
      n      = int'(amt);
      r      = eff_rot(n, WIDTH);
      // Shifting arithmetically by WIDTH-1 already replicates the sign bit
      // across the whole word, so larger amounts are clamped to it.
      s      = (n >= WIDTH) ? WIDTH - 1 : n;
      dbl    = {q, q};
      case (op)
         OP_SER: q_next = {q[WIDTH-2:0], sin};
         OP_ROR: begin
            dbl    = dbl >> r;
            q_next = dbl[WIDTH-1:0];
         end
         OP_ROL: begin
            dbl    = dbl << r;
            q_next = dbl[2*WIDTH-1:WIDTH];
         end
         OP_SHL: q_next = (n >= WIDTH) ? '0 : (q << n);
         OP_SHR: q_next = (n >= WIDTH) ? '0 : (q >> n);
         OP_SAR: q_next = $unsigned($signed(q) >>> s);
         default: q_next = q;
      endcase
   end

`else

   // The iterative build always moves one bit; the amount lives in the
   // top-level counter instead.
   logic unused_amt;
   assign unused_amt = ^amt;

   always_comb begin
      q_next = q;
      case (op)
         OP_SER: q_next = {q[WIDTH-2:0], sin};
         OP_ROR: q_next = {q[0], q[WIDTH-1:1]};
         OP_ROL: q_next = {q[WIDTH-2:0], q[WIDTH-1]};
         OP_SHL: q_next = {q[WIDTH-2:0], 1'b0};
         OP_SHR: q_next = {1'b0, q[WIDTH-1:1]};
         OP_SAR: q_next = {q[WIDTH-1], q[WIDTH-1:1]};
         default: q_next = q;
      endcase
   end

`endif

endmodule

// File: rtl/usr_seq.sv
// -----------------------------------------------------------------------------
// usr_seq -- parametrised universal shift register with command handshake.
//
// One accepted command (cmd_valid && cmd_ready) performs LOAD, a rotate,
// a logical/arithmetic shift, or an N-bit serial transfer (SER). Completion
// is signalled by a registered one-cycle `done` pulse in the first cycle in
// which `q` shows the final result.
//
// Configuration macro: USR_BARREL_EN
//   defined   : rotates/shifts finish on the accept edge (barrel shifter)
//   undefined : rotates/shifts iterate one bit per cycle in S_BUSY
//   SER always iterates one bit per cycle.
//
// Ports:
//   clk         in   1      rising-edge clock
//   rst         in   1      synchronous active-high reset
//   cmd_valid   in   1      command present
//   cmd_ready   out  1      block can accept a command
//   op          in   4      opcode, sampled on accept
//   amt         in   AMT_W  shift/transfer count, sampled on accept
//   din         in   WIDTH  parallel load data, sampled on accept
//   sin         in   1      serial input, sampled on each SER busy edge
//   q           out  WIDTH  register contents
//   sout        out  1      serial output (q MSB while sout_valid, else 0)
//   sout_valid  out  1      sout carries a valid bit this cycle
//   done        out  1      one-cycle completion pulse
// -----------------------------------------------------------------------------
module usr_seq
   import usr_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int AMT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [3:0]       op,
   input  logic [AMT_W-1:0] amt,
   input  logic [WIDTH-1:0] din,
   input  logic             sin,
   output logic [WIDTH-1:0] q,
   output logic             sout,
   output logic             sout_valid,
   output logic             done
);

   usr_state_t       state;
   logic [AMT_W-1:0] cnt;
   logic [3:0]       op_r;
   logic [3:0]       op_sel;
   logic [WIDTH-1:0] q_next;
   logic             accept;
   logic             is_shift;

   assign cmd_ready = (state == S_IDLE) && !rst;
   assign accept    = cmd_valid && cmd_ready;
   assign is_shift  = (op == OP_ROR) || (op == OP_ROL) || (op == OP_SHL) ||
                      (op == OP_SHR) || (op == OP_SAR);

   // While busy the stored opcode drives the shifter; in idle the incoming
   // one does, so the barrel build can finish on the accept edge.
   assign op_sel = (state == S_BUSY) ? op_r : op;

   // Outputs derived purely from registered state; S_BUSY never coincides
   // with done, so sout_valid and done are never high together.
   assign sout_valid = (state == S_BUSY) && (op_r == OP_SER);
   assign sout       = sout_valid ? q[WIDTH-1] : 1'b0;

   usr_shift_unit #(
      .WIDTH (WIDTH),
      .AMT_W (AMT_W)
   ) u_shift (
      .q      (q),
      .op     (op_sel),
      .amt    (amt),
      .sin    (sin),
      .q_next (q_next)
   );

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      if (rst) begin
         state <= S_IDLE;
         cnt   <= '0;
         op_r  <= OP_NOP;
         q     <= '0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (accept) begin
                  op_r <= op;
                  if (op == OP_LOAD) begin
                     q    <= din;
                     done <= 1'b1;
                  end else if ((op == OP_SER) && (amt != '0)) begin
                     state <= S_BUSY;
                     cnt   <= amt;
                  end else if (is_shift && (amt != '0)) begin
`ifdef USR_BARREL_EN
                     q    <= q_next;
                     done <= 1'b1;
`else
                     state <= S_BUSY;
                     cnt   <= amt;
`endif
                  end else begin
                     // NOP, unassigned opcodes and zero-amount ops.
                     done <= 1'b1;
                  end
               end
            end
            S_BUSY: begin
               q   <= q_next;
               cnt <= cnt - 1'b1;
               if (cnt == AMT_W'(1)) begin
                  state <= S_IDLE;
                  done  <= 1'b1;
               end
            end
         endcase
      end
   end

endmodule

// File: doc/usr_seq.md
# usr_seq

Parametrised universal shift register with a command handshake: one accepted command performs a parallel load, a multi-bit rotate, a logical or arithmetic shift, or an N-bit serial in/out transfer (SISO/SIPO/PISO). It is the next-generation replacement for the fixed 4-bit op-coded shift register. It sits between a command-issuing controller and serial or parallel datapaths, and reports completion with a one-cycle `done` pulse.

## Interface
- WIDTH, 8, register width in bits (≥2)
- AMT_W, $clog2(WIDTH)+1, width of the shift-amount field
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command
- op  in  4  opcode, sampled on accept
- amt  in  AMT_W  shift or transfer count, sampled on accept
- din  in  WIDTH  parallel load data, sampled on accept
- sin  in  1  serial input
- q  out  WIDTH  register contents
- sout  out  1  serial output
- sout_valid  out  1  `sout` carries a valid bit this cycle
- done  out  1  one-cycle pulse: the command has completed

## Operation
- Opcodes:
  - 0 NOP
  - 1 LOAD
  - 2 SER
  - 3 ROR
  - 4 ROL
  - 5 SHL (logical)
  - 6 SHR (logical)
  - 7 SAR (arithmetic)
  - 8–15 behave as NOP
- A command is accepted on an edge where `cmd_valid && cmd_ready`. `cmd_ready = (state==IDLE) && !rst`.
- FSM has two states, IDLE and BUSY, plus a down-counter `cnt[AMT_W-1:0]`.
- **NOP / LOAD.** Stay in IDLE. LOAD sets `q <= din` on the accept edge.
- **amt = 0.** For SER and shift/rotate ops, stay in IDLE; `q` is unchanged.
- **SER, amt > 0.** Go to BUSY with `cnt = amt`. Each BUSY edge:
  - `q <= {q[WIDTH-2:0], sin}`
  - `cnt--`
  - return to IDLE after the edge where `cnt == 1`
- **Shift/rotate, amt > 0, iterative.** Same BUSY sequence, one bit per edge.
- Rotates use `amt mod WIDTH`. Iterating the full `amt` gives the same result.
- SHL/SHR with `amt ≥ WIDTH` yield all zeros. SAR with `amt ≥ WIDTH` yields all copies of `q[WIDTH-1]`.
- `sout = sout_valid ? q[WIDTH-1] : 0`. `sout_valid` is high in every BUSY cycle of SER. The first bit shifted out is the original MSB.
- `sin` is sampled on each BUSY SER edge. It is ignored otherwise.
- `cmd_valid` while BUSY is not accepted. Upstream holds the command.

## Timing
- **Reset values:**
  - `q = 0`
  - `done = 0`
  - `sout = 0`
  - `sout_valid = 0`
  - `cmd_ready = 0` while `rst` is high; 1 from the first cycle after
  - state IDLE, `cnt = 0`
- Reset mid-command aborts it. No `done` is issued, and `q` clears on that edge.
- `done` is registered. It is high during the first cycle in which `q` shows the final result:
  - NOP, LOAD, `amt=0`: one cycle after accept
  - SER and iterative shifts: `amt` cycles after the accept edge, i.e. after the last BUSY edge
- Back-to-back commands are allowed. A new command may be accepted in the same cycle `done` is high.
- `done` and `sout_valid` are never high together for the same command.

## Configuration
- `USR_BARREL_EN` defined:
  - ROR/ROL/SHL/SHR/SAR complete on the accept edge using a barrel shifter
  - no BUSY state; `done` one cycle after accept
  - SER still iterates bit by bit
- Undefined: shifts iterate one bit per cycle, as described above. This is the smaller area option.
- Final `q` values are identical in both builds.

## Structure
- `usr_pkg` holds:
  - opcode localparams `OP_NOP` … `OP_SAR`
  - the state enum `usr_state_t` (`S_IDLE`, `S_BUSY`)
  - a helper that computes the effective rotate amount
- Sub-module `usr_shift_unit` is a combinational WIDTH-parametrised shifter.
  - Inputs: `q`, `op`, `amt`, `sin`; output: next value.
  - It is a one-step shifter when `USR_BARREL_EN` is undefined and a barrel shifter when defined.
- Top level holds the FSM, `cnt`, `q`, and `done`.

## Test plan
All scenarios use WIDTH=8.
- **LOAD.** `din=8'hA5` → `q=A5`. `done` one cycle after accept; `cmd_ready` stays 1.
- **ROR.** From `q=A5`, ROR `amt=3` → `q=B4`. `done` 3 cycles after accept, or 1 with `USR_BARREL_EN`. `cmd_valid` held during BUSY is not accepted.
- **SAR / SHR / ROL overflow.** From `q=96`:
  - SAR `amt=2` → `E5`
  - then SHR `amt=9` → `00`
  - LOAD `81`, then ROL `amt=9` → `03`
- **SER.** From `q=A5`, SER `amt=8` with `sin` = 1,0,0,1,1,0,1,1:
  - `sout` = 1,0,1,0,0,1,0,1 over exactly 8 `sout_valid` cycles
  - final `q=9B`
  - then `done`
- **Reset mid-SER.** Assert `rst` after 3 bits → next cycle `q=00`, `sout_valid=0`, no `done`. `cmd_ready=1` the cycle after `rst` drops.
- **Degenerate commands.** ROL `amt=0`, and op `4'hF` → `q` unchanged, `done` one cycle after accept, no BUSY cycles.
